// File: rtl/scc68070_timer_unit.sv
// SCC68070 timer block: prescaled T0 reload timer plus up to two general timers
// with match / capture / event-count modes, W1C status and a registered irq.

module scc68070_timer_ch (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic [1:0]  evsel,
  input  logic        pin,
  input  logic        wr_en,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  input  logic [15:0] rr,
  output logic [15:0] cnt,
  output logic [15:0] cap,
  output logic        ma_set,
  output logic        cap_set,
  output logic        ov_set
);
  logic s1, s2, prev, rise, fall, ev, inc;
  logic [15:0] cnt_inc;

  assign rise    = s2 & ~prev;
  assign fall    = ~s2 & prev;
  assign ev      = (evsel[0] & rise) | (evsel[1] & fall);
  assign cnt_inc = cnt + 16'd1;

  always_comb begin
    inc = 1'b0;
    case (mode)
      2'b01, 2'b10: inc = tick;
      2'b11:        inc = ev;
      default:      inc = 1'b0;
    endcase
  end

  // A bus write to the counter wins over the increment, so no flags either.
  assign ov_set  = inc & ~wr_en & (cnt == 16'hFFFF);
  assign ma_set  = inc & ~wr_en & (mode == 2'b01) & (cnt_inc == rr);
  assign cap_set = (mode == 2'b10) & ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      cnt  <= '0;
      cap  <= '0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      prev <= s2;
      if (wr_en)    cnt <= {be[1] ? wdata[15:8] : cnt[15:8], be[0] ? wdata[7:0] : cnt[7:0]};
      else if (inc) cnt <= cnt_inc;
      if (cap_set)  cap <= cnt;
    end
  end
endmodule

module scc68070_timer_unit #(
  parameter int PRESCALE = 96,
  parameter int NUM_CH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [1:0]  bus_be,
  input  logic [2:0]  bus_addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  input  logic [1:0]  t_in,
  output logic        irq
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]      presc;
  logic               tick, wr, t0_wr, t0_ov;
  logic [7:0]         tcr;
  logic [7:1]         tsr, tsr_set, tsr_clr;
  logic [15:0]        rr, t0;
  logic [1:0][15:0]   cnt, cap;
  logic [1:0]         ma_set, cap_set, ov_set;

  assign tick  = (presc == PW'(PRESCALE - 1));
  assign wr    = bus_req & bus_we & (|bus_be);
  assign t0_wr = wr & (bus_addr == 3'd2);
  assign t0_ov = tick & ~t0_wr & (t0 == 16'hFFFF);

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be,
                                        input logic [15:0] d);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      scc68070_timer_ch u_ch (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .mode    (tcr[5-4*i -: 2]),
        .evsel   (tcr[7-4*i -: 2]),
        .pin     (t_in[i]),
        .wr_en   (wr & (bus_addr == 3'(3 + i))),
        .be      (bus_be),
        .wdata   (bus_wdata),
        .rr      (rr),
        .cnt     (cnt[i]),
        .cap     (cap[i]),
        .ma_set  (ma_set[i]),
        .cap_set (cap_set[i]),
        .ov_set  (ov_set[i])
      );
    end else begin : g_off
      assign cnt[i]     = '0;
      assign cap[i]     = '0;
      assign ma_set[i]  = 1'b0;
      assign cap_set[i] = 1'b0;
      assign ov_set[i]  = 1'b0;
    end
  end

  // Status bits per channel sit in groups of three: MA, CAP, OV.
  always_comb begin
    tsr_set    = '0;
    tsr_set[7] = t0_ov;
    for (int i = 0; i < 2; i++) begin
      tsr_set[6-3*i] = ma_set[i];
      tsr_set[5-3*i] = cap_set[i];
      tsr_set[4-3*i] = ov_set[i];
    end
    tsr_clr = (wr && bus_addr == 3'd0 && bus_be[1]) ? bus_wdata[15:9] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tcr   <= '0;
      tsr   <= '0;
      rr    <= '0;
      t0    <= '0;
      irq   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      tsr   <= (tsr & ~tsr_clr) | tsr_set;
      irq   <= |tsr;
      if (wr && bus_addr == 3'd0 && bus_be[0]) tcr <= bus_wdata[7:0];
      if (wr && bus_addr == 3'd1) rr <= merge(rr, bus_be, bus_wdata);
      if (t0_wr)     t0 <= merge(t0, bus_be, bus_wdata);
      else if (tick) t0 <= (t0 == 16'hFFFF) ? rr : t0 + 16'd1;
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      3'd0:    bus_rdata = {tsr, 1'b0, tcr};
      3'd1:    bus_rdata = rr;
      3'd2:    bus_rdata = t0;
      3'd3:    bus_rdata = cnt[0];
      3'd4:    bus_rdata = cnt[1];
      3'd5:    bus_rdata = cap[0];
      3'd6:    bus_rdata = cap[1];
      default: bus_rdata = '0;
    endcase
  end
endmodule
